// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle control unit.
// States, opcodes, instruction classes and datapath select codes.
package mc_ctrl_pkg;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_S = 3'b100;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    CL_NONE,
    CL_R,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BEQ,
    CL_BLT
  } cls_e;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier and datapath
// select generator for the multi-cycle control unit.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output cls_e        cls,
  output logic        legal,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_sub;
  logic       unused_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign f7_sub = inst[30];
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    cls = CL_NONE;
    case (opcode)
      OP_R:     cls = CL_R;
      OP_IMM:   if (funct3 == F3_ADD) cls = CL_ADDI;
      OP_LOAD:  if (funct3 == F3_LW) cls = CL_LW;
      OP_STORE: if (funct3 == F3_SW) cls = CL_SW;
      OP_LUI:   cls = CL_LUI;
      OP_AUIPC: cls = CL_AUIPC;
      OP_JAL:   cls = CL_JAL;
      OP_JALR:  cls = CL_JALR;
      OP_BR: begin
        if (funct3 == F3_BEQ) cls = CL_BEQ;
        else if (funct3 == F3_BLT) cls = CL_BLT;
      end
      default:  cls = CL_NONE;
    endcase
  end

  assign legal = (cls != CL_NONE);

  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = WB_ALU;
    case (cls)
      CL_R:     alu_op = f7_sub ? ALU_SUB : ALU_ADD;
      CL_ADDI:  alu_b_sel = 1'b1;
      CL_LW: begin
        alu_b_sel = 1'b1;
        wb_sel    = WB_MEM;
      end
      CL_SW: begin
        imm_type  = IMM_S;
        alu_b_sel = 1'b1;
      end
      CL_LUI: begin
        imm_type  = IMM_U;
        alu_b_sel = 1'b1;
        alu_op    = ALU_PASS;
      end
      CL_AUIPC: begin
        imm_type  = IMM_U;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      CL_JAL: begin
        imm_type  = IMM_J;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        wb_sel    = WB_PC4;
      end
      CL_JALR: begin
        alu_b_sel = 1'b1;
        wb_sel    = WB_PC4;
      end
      CL_BEQ, CL_BLT: begin
        imm_type  = IMM_B;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I subset,
// sole writer of PC and IR, stalling on the shared memory port.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_type,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state_o
);

  logic [2:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  cls_e       dec_cls;
  logic       dec_legal;
  logic [2:0] dec_imm;
  logic [1:0] dec_op;
  logic       dec_a;
  logic       dec_b;
  logic [1:0] dec_wb;

  logic       is_br;
  logic       is_mem;
  logic       taken;
  logic       dec_on;

  mc_decode u_dec (
    .inst      (inst),
    .cls       (dec_cls),
    .legal     (dec_legal),
    .imm_type  (dec_imm),
    .alu_op    (dec_op),
    .alu_a_sel (dec_a),
    .alu_b_sel (dec_b),
    .wb_sel    (dec_wb)
  );

  assign is_br  = (dec_cls == CL_BEQ) || (dec_cls == CL_BLT);
  assign is_mem = (dec_cls == CL_LW) || (dec_cls == CL_SW);
  assign taken  = ((dec_cls == CL_BEQ) && br_eq) ||
                  ((dec_cls == CL_BLT) && br_lt);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (dec_legal) begin
          state_d = ST_EX;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EX: begin
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = taken ? PC_ALU : PC_PLUS4;
          state_d = ST_IF;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec_cls == CL_SW);
        if (mem_ready) begin
          if (dec_cls == CL_SW) begin
            pc_we   = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_IF;
        if (dec_cls == CL_JAL) pc_sel = PC_ALU;
        else if (dec_cls == CL_JALR) pc_sel = PC_JALR;
      end
      ST_HALT: ;
      default: state_d = ST_IF;
    endcase
    // reset silences everything in the same cycle, including a pending request
    if (!rstn) begin
      state_d   = ST_IF;
      illegal_d = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      rf_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign dec_on = rstn && ((state_q == ST_ID) || (state_q == ST_EX) ||
                           (state_q == ST_MEM) || (state_q == ST_WB));

  assign imm_type  = dec_on ? dec_imm : 3'b000;
  assign alu_op    = dec_on ? dec_op : 2'b00;
  assign alu_a_sel = dec_on && dec_a;
  assign alu_b_sel = dec_on && dec_b;
  assign wb_sel    = dec_on ? dec_wb : 2'b00;
  assign retire    = pc_we;
  assign illegal   = rstn && illegal_q;
  assign state_o   = rstn ? state_q : ST_IF;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized lockstep check of mc_ctrl against a
// per-instruction cycle-sequence model, plus directed literal checks.
module tb_mc_ctrl;

  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_LUI = 4;
  localparam int C_AUIPC = 5, C_JAL = 6, C_JALR = 7, C_BEQ = 8;
  localparam int C_BLT = 9, C_ILL = 10;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq;
    logic       mwe;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsel;
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic [1:0] op;
    logic       rfwe;
    logic [1:0] wb;
    logic       ret;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        br_eq = 1'b0;
  logic        br_lt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_type;
  logic        alu_a_sel, alu_b_sel;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        retire, illegal;
  logic [2:0]  state_o;

  mc_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .inst      (inst),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_type  (imm_type),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .retire    (retire),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  exp_t  act;
  exp_t  exp_q;
  logic  exp_v = 1'b0;
  string tag_s = "none";
  int    n_vec = 0;
  int    n_err = 0;
  int    icnt = 0;
  int    last_cpi = 0;

  assign act = {state_o, mem_req, mem_we, ir_we, pc_we, pc_sel, imm_type,
                alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, illegal};

  always @(negedge clk) begin
    if (exp_v) begin
      n_vec++;
      if (act !== exp_q) begin
        n_err++;
        $display("FAIL cyc %s @%0t: got %h want %h", tag_s, $time, act, exp_q);
      end
    end
    if (!rstn) icnt = 0;
    else begin
      icnt++;
      if (retire) begin
        last_cpi = icnt;
        icnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic drive(input exp_t e, input logic rdy, input logic eq,
                       input logic lt, input logic [31:0] in,
                       input logic rst, input string tag);
    @(posedge clk);
    #1;
    rstn = rst;
    mem_ready = rdy;
    br_eq = eq;
    br_lt = lt;
    inst = in;
    exp_q = e;
    exp_v = 1'b1;
    tag_s = tag;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Decode columns of the instruction table, visible only in ID..WB
  function automatic exp_t base(input logic [2:0] st, input int cls,
                                input logic [31:0] in);
    exp_t e;
    e = '0;
    e.st = st;
    if (st >= 3'd1 && st <= 3'd4) begin
      case (cls)
        C_R:     e.op = in[30] ? 2'b01 : 2'b00;
        C_ADDI:  e.b = 1'b1;
        C_LW:    begin e.b = 1'b1; e.wb = 2'b01; end
        C_SW:    begin e.imm = 3'b100; e.b = 1'b1; end
        C_LUI:   begin e.imm = 3'b001; e.b = 1'b1; e.op = 2'b10; end
        C_AUIPC: begin e.imm = 3'b001; e.a = 1'b1; e.b = 1'b1; end
        C_JAL:   begin e.imm = 3'b010; e.a = 1'b1; e.b = 1'b1; e.wb = 2'b10; end
        C_JALR:  begin e.b = 1'b1; e.wb = 2'b10; end
        C_BEQ, C_BLT: begin e.imm = 3'b011; e.a = 1'b1; e.b = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] gen(input int cls);
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    case (cls)
      C_R:     r[6:0] = 7'b0110011;
      C_ADDI:  begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
      C_LW:    begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
      C_SW:    begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
      C_LUI:   r[6:0] = 7'b0110111;
      C_AUIPC: r[6:0] = 7'b0010111;
      C_JAL:   r[6:0] = 7'b1101111;
      C_JALR:  r[6:0] = 7'b1100111;
      C_BEQ:   begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
      C_BLT:   begin r[6:0] = 7'b1100011; r[14:12] = 3'b100; end
      default: begin
        f3 = 3'($urandom_range(1, 7));
        case ($urandom_range(0, 3))
          0: r = 32'hFFFF_FFFF;
          1: begin r[6:0] = 7'b0010011; r[14:12] = f3; end
          2: begin
            r[6:0] = 7'b1100011;
            r[14:12] = (f3 == 3'b100) ? 3'b111 : f3;
          end
          default: begin
            r[6:0] = rb() ? 7'b0000011 : 7'b0100011;
            r[14:12] = (f3 == 3'b010) ? 3'b011 : f3;
          end
        endcase
      end
    endcase
    return r;
  endfunction

  // One instruction as a cycle sequence; abort_mem stops after one MEM wait
  task automatic run_instr(input int cls, input logic [31:0] in,
                           input int wif, input int wmem,
                           input logic eq, input logic lt,
                           input logic abort_mem);
    exp_t e;
    for (int i = 0; i < wif; i++) begin
      e = base(3'd0, cls, in);
      e.mreq = 1'b1;
      drive(e, 1'b0, rb(), rb(), $urandom, 1'b1, "if_wait");
    end
    e = base(3'd0, cls, in);
    e.mreq = 1'b1;
    e.irwe = 1'b1;
    drive(e, 1'b1, rb(), rb(), $urandom, 1'b1, "if");
    e = base(3'd1, cls, in);
    drive(e, rb(), rb(), rb(), in, 1'b1, "id");
    if (cls == C_ILL) begin
      for (int i = 0; i < 3; i++) begin
        e = '0;
        e.st = 3'd7;
        e.ill = 1'b1;
        drive(e, rb(), rb(), rb(), in, 1'b1, "halt");
      end
      return;
    end
    e = base(3'd2, cls, in);
    if (cls == C_BEQ || cls == C_BLT) begin
      e.pcwe = 1'b1;
      e.ret = 1'b1;
      e.pcsel = ((cls == C_BEQ && eq) || (cls == C_BLT && lt)) ? 2'b01 : 2'b00;
      drive(e, rb(), eq, lt, in, 1'b1, "ex_br");
      return;
    end
    drive(e, rb(), eq, lt, in, 1'b1, "ex");
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i < wmem; i++) begin
        e = base(3'd3, cls, in);
        e.mreq = 1'b1;
        e.mwe = (cls == C_SW);
        drive(e, 1'b0, rb(), rb(), in, 1'b1, "mem_wait");
        if (abort_mem) return;
      end
      e = base(3'd3, cls, in);
      e.mreq = 1'b1;
      e.mwe = (cls == C_SW);
      if (cls == C_SW) begin
        e.pcwe = 1'b1;
        e.ret = 1'b1;
      end
      drive(e, 1'b1, rb(), rb(), in, 1'b1, "mem");
      if (cls == C_SW) return;
    end
    e = base(3'd4, cls, in);
    e.rfwe = 1'b1;
    e.pcwe = 1'b1;
    e.ret = 1'b1;
    if (cls == C_JAL) e.pcsel = 2'b01;
    else if (cls == C_JALR) e.pcsel = 2'b10;
    drive(e, rb(), rb(), rb(), in, 1'b1, "wb");
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    z = '0;
    for (int i = 0; i < n; i++)
      drive(z, rb(), rb(), rb(), $urandom, 1'b0, "reset");
  endtask

  initial begin
    int cls;
    do_reset(2);

    run_instr(C_ADDI, 32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("addi_rf_we", 32'(rf_we), 32'd1);
    chk("addi_imm", 32'(imm_type), 32'd0);
    chk("addi_bsel", 32'(alu_b_sel), 32'd1);
    chk("addi_cpi", last_cpi, 32'd4);

    run_instr(C_LW, 32'h0000_A103, 2, 2, 1'b0, 1'b0, 1'b0);
    settle();
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    chk("lw_cpi", last_cpi, 32'd9);

    run_instr(C_BEQ, 32'h0020_8463, 0, 0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("beq_t_pcsel", 32'(pc_sel), 32'd1);
    chk("beq_imm", 32'(imm_type), 32'd3);
    chk("beq_cpi", last_cpi, 32'd3);
    run_instr(C_BEQ, 32'h0020_8463, 0, 0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("beq_nt_pcsel", 32'(pc_sel), 32'd0);

    run_instr(C_JAL, 32'h0080_00EF, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("jal_imm", 32'(imm_type), 32'd2);
    chk("jal_wb_sel", 32'(wb_sel), 32'd2);
    chk("jal_pcsel", 32'(pc_sel), 32'd1);
    run_instr(C_JALR, 32'h0000_80E7, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("jalr_pcsel", 32'(pc_sel), 32'd2);

    run_instr(C_ILL, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_state", 32'(state_o), 32'd7);
    chk("ill_mreq", 32'(mem_req), 32'd0);
    do_reset(1);
    run_instr(C_ADDI, 32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("post_rst_ill", 32'(illegal), 32'd0);

    run_instr(C_SW, gen(C_SW), 0, 3, 1'b0, 1'b0, 1'b1);
    do_reset(2);
    settle();
    chk("sw_rst_state", 32'(state_o), 32'd0);
    chk("sw_rst_mreq", 32'(mem_req), 32'd0);
    chk("sw_rst_ret", 32'(retire), 32'd0);
    run_instr(C_R, gen(C_R), 0, 0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      cls = ($urandom_range(0, 19) == 0) ? C_ILL : int'($urandom_range(0, 9));
      run_instr(cls, gen(cls), int'($urandom_range(0, 3)) % 3,
                int'($urandom_range(0, 3)) % 3, rb(), rb(), 1'b0);
      if (cls == C_ILL) do_reset(int'($urandom_range(1, 2)));
    end

    settle();
    exp_v = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the RV32I-subset CPU. Sequences each instruction through fetch, decode, execute, memory and write-back, stalling on a shared instruction/data memory port. Drives every datapath select, including `imm_type` for the immediate generator, the ALU operation, the register-file write and the PC update. It sits between the instruction register and the datapath muxes and is the only writer of PC and IR.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `inst`  in  32  current IR contents (valid from ID onward).
- `br_eq`  in  1  comparator: rs1 == rs2.
- `br_lt`  in  1  comparator: signed rs1 < rs2.
- `mem_ready`  in  1  memory port completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  store request (valid with `mem_req`).
- `ir_we`  out  1  latch memory read data into IR.
- `pc_we`  out  1  load PC.
- `pc_sel`  out  2  PC source: 00 = pc+4, 01 = alu_out, 10 = alu_out & ~1.
- `imm_type`  out  3  000 = I, 001 = U, 010 = J, 011 = B, 100 = S.
- `alu_a_sel`  out  1  0 = rs1, 1 = pc.
- `alu_b_sel`  out  1  0 = rs2, 1 = imm.
- `alu_op`  out  2  00 = ADD, 01 = SUB, 10 = PASS_B.
- `rf_we`  out  1  register-file write.
- `wb_sel`  out  2  write-back source: 00 = alu, 01 = mem data, 10 = pc+4.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  sticky flag; set on an undecodable instruction.
- `state_o`  out  3  current state, for debug.

## Operation
States (3-bit): IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, HALT = 7.
- IF: `mem_req` = 1, `mem_we` = 0. On `mem_ready`, `ir_we` = 1 and go to ID; otherwise stay in IF.
- ID: decode `inst`.
  - Legal instruction: go to EX.
  - Illegal instruction: set `illegal` and go to HALT.
- Legal instructions:
  - R-type, opcode 0110011: funct7[5] selects SUB, otherwise ADD.
  - addi: 0010011, funct3 000.
  - lw: 0000011, funct3 010.
  - sw: 0100011, funct3 010.
  - lui: 0110111.
  - auipc: 0010111.
  - jal: 1101111.
  - jalr: 1100111.
  - beq / blt: 1100011, funct3 000 / 100.
- EX: ALU operates on the selects for the instruction class.
  - R-type: rs1, rs2.
  - addi / lw / sw / jalr: rs1, imm.
  - auipc / jal / branch: pc, imm.
  - lui: PASS_B of imm.
- From EX:
  - Branch completes in EX: `pc_we` = 1; `pc_sel` = 01 if taken (beq & `br_eq`, or blt & `br_lt`), else 00; `retire` = 1; go to IF.
  - lw / sw go to MEM.
  - All other classes go to WB.
- MEM: `mem_req` = 1, `mem_we` = sw.
  - Stay in MEM until `mem_ready`.
  - Then sw retires (`pc_we`, `pc_sel` = 00, `retire`) and goes to IF.
  - lw goes to WB.
- WB: `rf_we` = 1, `pc_we` = 1, `retire` = 1, go to IF.
  - `wb_sel`: lw = 01; jal / jalr = 10; else 00.
  - `pc_sel`: jal = 01; jalr = 10; else 00.
  - rd = x0 is written anyway; the register file discards it.
- HALT: absorbing until reset. All strobes are 0.
- Decode fields (`imm_type`, `alu_*`, `wb_sel`) are combinational from `inst` and state. They are valid in ID through WB and are 0 in IF and HALT.

## Timing
- Reset (`rstn` = 0 at an edge), from any state including mid-wait: state = IF, `illegal` = 0.
  - All outputs are 0 in the reset cycle.
  - An outstanding `mem_req` is dropped in the same cycle.
- Zero-wait memory (`mem_ready` high in the first request cycle), cycles per instruction:
  - branch = 3
  - R-type / addi / lui / auipc / jal / jalr / sw = 4
  - lw = 5
- Each extra `mem_ready` low cycle adds 1 cycle.
- `mem_req`, `mem_we` and the address select stay stable while waiting.
- `mem_ready` outside IF or MEM is ignored.
- `pc_we` and `retire` are coincident single-cycle pulses, exactly once per legal instruction.
- PC holds the current instruction address from IF through the completion cycle, so pc+4 and pc+imm are stable across all states.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum;
  - opcode and funct3 constants;
  - `imm_type`, `alu_op`, `pc_sel` and `wb_sel` code constants.
- Sub-module `mc_decode`: combinational `inst` → class, `imm_type`, `alu_op`, `alu_*_sel`, `wb_sel`, legal.
- The FSM and strobe generation live in `mc_ctrl`.

## Test plan
- Reset, then `inst` = addi x1,x0,5 (0x00500093) with `mem_ready` tied 1 → states 0,1,2,4.
  - WB: `rf_we`, `imm_type` = 000, `alu_b_sel` = 1.
  - `retire` at cycle 4.
- lw (0x0000A103) with `mem_ready` low for 2 cycles in both IF and MEM → 9 cycles.
  - `mem_req` is held throughout both waits.
  - WB has `wb_sel` = 01.
- beq (0x00208463):
  - `br_eq` = 1 → EX: `pc_sel` = 01, `imm_type` = 011, 3-cycle retire.
  - `br_eq` = 0 → EX: `pc_sel` = 00.
- jal (0x008000EF) → `imm_type` = 010, WB: `wb_sel` = 10, `pc_sel` = 01.
  - jalr (0x000080E7) → WB: `pc_sel` = 10.
- `inst` = 0xFFFFFFFF → `illegal` = 1, state 7, no further `mem_req`.
  - `rstn` low for 1 cycle → IF, `illegal` = 0.
- `rstn` asserted while in MEM waiting on sw → next cycle state 0, `mem_req` = 0, no `retire`.
